// File: rtl/seg7_bcd_feeder.sv
// Binary-to-BCD front end for a 4-digit seven-segment driver: double-dabble one bit per clock,
// with hex passthrough and an overflow code for decimal values above 9999.
module seg7_bcd_feeder #(
  parameter int unsigned IN_W     = 16,
  parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_value,
  input  logic            hex_mode,
  output logic [15:0]     data,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_LOAD = 2'd2} state_t;
  typedef enum logic [1:0] {K_DEC = 2'd0, K_HEX = 2'd1, K_OVF = 2'd2} kind_t;

  localparam int unsigned     CNT_W    = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] DEC_MAX  = IN_W'(16'd9999);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W);

  // Shift-add-3 correction: every BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] bcd);
    logic [15:0] res;
    res = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t           r_state;
  state_t           w_next;
  kind_t            r_kind;
  logic [IN_W-1:0]  r_bin;
  logic [15:0]      r_bcd;
  logic [15:0]      r_hex;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_too_big;
  logic [15:0] w_in_ext;
  logic [15:0] w_bcd_adj;

  assign w_accept  = in_valid & in_ready;
  assign w_too_big = (in_value > DEC_MAX);
  assign w_in_ext  = 16'(in_value);
  assign w_bcd_adj = add3_nibbles(r_bcd);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (hex_mode || w_too_big) ? S_LOAD : S_CONV;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CONV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_CONV;
        end
      end
      S_LOAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    if (r_state == S_IDLE) begin
      in_ready = 1'b1;
      busy     = 1'b0;
    end else begin
      in_ready = 1'b0;
      busy     = 1'b1;
    end
  end

  // Conversion scratch: capture on accept, then shift one binary bit into the BCD digits per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind <= K_DEC;
      r_bin  <= '0;
      r_bcd  <= 16'h0000;
      r_hex  <= 16'h0000;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_kind <= hex_mode ? K_HEX : (w_too_big ? K_OVF : K_DEC);
            r_hex  <= w_in_ext;
            r_bin  <= in_value;
            r_bcd  <= 16'h0000;
            r_cnt  <= CNT_INIT;
          end else begin
            r_cnt  <= r_cnt;
          end
        end
        S_CONV: begin
          r_bcd <= {w_bcd_adj[14:0], r_bin[IN_W-1]};
          r_bin <= {r_bin[IN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Visible result: only written when leaving LOAD, so scratch never reaches the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= 16'h0000;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (r_state == S_LOAD);
      if (r_state == S_LOAD) begin
        case (r_kind)
          K_HEX: begin
            data <= r_hex;
            ovf  <= 1'b0;
          end
          K_OVF: begin
            data <= OVF_CODE;
            ovf  <= 1'b1;
          end
          default: begin
            data <= r_bcd;
            ovf  <= 1'b0;
          end
        endcase
      end else begin
        data <= data;
        ovf  <= ovf;
      end
    end
  end

endmodule

// File: doc/seg7_bcd_feeder.md
Name: seg7_bcd_feeder

Overview:
- Sequential binary-to-BCD converter placed directly upstream of the 4-digit seven-segment display driver.
- Accepts a binary value through a valid/ready handshake and converts it with the shift-add-3 (double-dabble) method, one bit per clock.
- Holds the packed 4-digit result on `data`, which feeds the driver's 16-bit data input.
- A hex-passthrough mode displays raw values; out-of-range decimal values display an overflow code.

Parameters:
- IN_W, 16: binary input width. Legal range 14..16. Also sets the number of conversion iterations.
- OVF_CODE, 16'hEEEE: pattern driven on `data` when a decimal value exceeds 9999.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  `in_value` and `hex_mode` are offered.
- in_ready  out  1  block can accept. High only in IDLE.
- in_value  in  IN_W  binary value to display.
- hex_mode  in  1  1 = show `in_value[15:0]` raw (zero-extended if IN_W<16); 0 = decimal.
- data  out  16  packed digits {d3,d2,d1,d0}, d3 most significant, to display driver.
- busy  out  1  equals ~in_ready.
- done  out  1  one-cycle pulse, high in the cycle after `data` updates.
- ovf  out  1  last completed request was decimal and >9999. Updates together with `data`.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, data=16'h0000, done=0, ovf=0, in_ready=1, busy=0.
  - Scratch registers cleared.
  - A conversion in progress is abandoned with no partial update.
- States: IDLE, CONV, LOAD.
- Accept occurs at posedge k when `in_valid` & `in_ready`. `in_value` and `hex_mode` are sampled only then and ignored at all other times.
- IDLE->LOAD on accept when `hex_mode`=1, or when `hex_mode`=0 and `in_value` >9999.
- IDLE->CONV on accept when `hex_mode`=0 and `in_value` ≤9999:
  - At edge k, load the binary shift register with `in_value`, clear the 16-bit BCD scratch, and set the iteration counter to IN_W.
- CONV, each edge:
  - First, every BCD nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1; the bin MSB enters the bcd LSB.
  - The counter decrements.
  - After IN_W iterations (edges k+1..k+IN_W) go to LOAD.
- LOAD, one cycle. At its exit edge, the result is written to `data`, `ovf` is updated and the state returns to IDLE:
  - decimal: `data`=bcd scratch, `ovf`=0.
  - hex: `data`=value, `ovf`=0.
  - overflow: `data`=OVF_CODE, `ovf`=1.
- `done` is registered: high for exactly the one cycle after the `data` update edge.
- Latency from accept edge k to `data` update edge:
  - decimal in range: k+IN_W+1.
  - hex or overflow: k+1.
- `data` holds its value between updates and never shows intermediate scratch.
- Busy or backpressure: while in CONV or LOAD, `in_ready`=0 and `in_valid` is ignored. No queuing.
- Back-to-back: `in_ready` returns high in the same cycle `done` is high, so a new accept can occur at the edge ending the `done` cycle.
- Width rule: values ≤9999 never carry out of 4 BCD digits, so the 16-bit scratch suffices for IN_W=16. The range check uses the full IN_W-bit value.
- Boundary values:
  - 0 -> 16'h0000.
  - 9999 -> 16'h9999, `ovf`=0.
  - 10000 -> OVF_CODE.
  - Max IN_W value -> OVF_CODE.

Test Plan:
- Assert `rst` mid-cycle with no clock edge -> immediately `data`=0000, `in_ready`=1, `done`=0, `ovf`=0.
- Accept decimal 1234 (IN_W=16) at edge k -> `in_ready` low at k..k+16; `data`=16'h1234 after edge k+17; `done` high one cycle; `ovf`=0.
- Decimal 9999 -> 16'h9999, `ovf`=0. Then 10000 -> 16'hEEEE, `ovf`=1 after edge k+1. Then 65535 -> 16'hEEEE, `ovf`=1.
- `hex_mode`=1 with 16'hBEEF -> `data`=16'hBEEF after edge k+1, `ovf`=0. Changing `hex_mode` after accept has no effect.
- Hold `in_valid` with value 42 while busy converting 7 -> 42 not taken; `data` goes to 0007; 42 is accepted in the `done` cycle; `data` goes to 0042 at 17 edges later.
- Start decimal 5678, assert `rst` at iteration 8 -> `data`=0000 immediately. Then decimal 0 -> 16'h0000 with `done` pulse.
